otter_lsu_align: RTL

Load/store alignment unit between the OTTER pipeline's memory stage and data port 2 of the byte-addressable OTTER memory. It accepts one load or store at a time and checks natural alignment. Naturally aligned or MMIO accesses pass through as a single memory operation. Misaligned halfword/word accesses are split into sequential byte operations, and load bytes are reassembled and extended before being returned.

---
 rtl/otter_lsu_align.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/otter_lsu_align.sv
// otter_lsu_align: load/store alignment unit for OTTER memory data port 2.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned requests instead of splitting them.
module otter_lsu_align #(
  parameter logic [31:0] IO_BASE = 32'h11000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [31:0] LSU_ADDR,
  input  logic [1:0]  LSU_SIZE,
  input  logic        LSU_SIGN,
  input  logic [31:0] LSU_WDATA,
  output logic        LSU_BUSY,
  output logic        LSU_DONE,
  output logic [31:0] LSU_RDATA,
  output logic        LSU_MISALIGN,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, asm_q, rdata_q;
  logic [1:0]  size_q, k_q, last_k_q;
  logic        we_q, sign_q, split_q, mis_q;

  logic        req_mis, k_last, trap_act;
  logic [4:0]  bsel;
  logic [31:0] asm_nxt, load_res;

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zext);
    logic signed [15:0] hs;
    logic signed [31:0] ext;
    hs  = $signed(h);
    ext = hs;
    return zext ? {16'h0000, h} : ext;
  endfunction

  // MMIO space is never split, whatever the alignment
  always_comb begin
    req_mis = 1'b0;
    if (LSU_SIZE == 2'd1)      req_mis = LSU_ADDR[0];
    else if (LSU_SIZE == 2'd2) req_mis = (LSU_ADDR[1:0] != 2'b00);
    if (LSU_ADDR >= IO_BASE)   req_mis = 1'b0;
  end

  assign trap_act = TRAP_EN & mis_q;
  assign k_last   = (k_q == last_k_q);
  assign bsel     = {k_q, 3'b000};

  always_comb begin
    asm_nxt             = asm_q;
    asm_nxt[bsel +: 8]  = MEM_DOUT2[7:0];
    load_res            = MEM_DOUT2;
    if (split_q)
      load_res = (size_q == 2'd1) ? ext_half(asm_nxt[15:0], sign_q) : asm_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (LSU_REQ) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (trap_act)    state_nxt = ST_FIN;
        else if (!we_q)  state_nxt = ST_WAIT;
        else if (k_last) state_nxt = ST_FIN;
      end
      ST_WAIT:  state_nxt = k_last ? ST_FIN : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // request latch, byte counter and load assembly
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      k_q      <= '0;
      last_k_q <= '0;
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      split_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (LSU_REQ) begin
          we_q     <= LSU_WE;
          addr_q   <= LSU_ADDR;
          size_q   <= LSU_SIZE;
          sign_q   <= LSU_SIGN;
          wdata_q  <= LSU_WDATA;
          mis_q    <= req_mis;
          split_q  <= req_mis & ~TRAP_EN;
          last_k_q <= (req_mis & ~TRAP_EN) ? ((LSU_SIZE == 2'd1) ? 2'd1 : 2'd3) : 2'd0;
          k_q      <= 2'd0;
          asm_q    <= '0;
        end
        ST_ISSUE: if (we_q && !trap_act && !k_last) k_q <= k_q + 2'd1;
        ST_WAIT: begin
          asm_q <= asm_nxt;
          if (k_last) rdata_q <= load_res;
          else        k_q     <= k_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // memory port decode; address is held through WAIT for the sliced read data
  always_comb begin
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIZE   = 2'd0;
    MEM_SIGN   = 1'b0;
    if ((state == ST_ISSUE || state == ST_WAIT) && !trap_act) begin
      MEM_ADDR2 = addr_q + {30'd0, k_q};
      if (split_q) begin
        MEM_SIZE = 2'd0;
        MEM_SIGN = 1'b1;
        MEM_DIN2 = {24'd0, wdata_q[bsel +: 8]};
      end else begin
        MEM_SIZE = size_q;
        MEM_SIGN = sign_q;
        MEM_DIN2 = wdata_q;
      end
      if (state == ST_ISSUE) begin
        MEM_WRITE2 = we_q;
        MEM_READ2  = ~we_q;
      end
    end
  end

  assign LSU_BUSY  = (state != ST_IDLE);
  assign LSU_DONE  = (state == ST_FIN);
  assign LSU_RDATA = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign LSU_MISALIGN = (state == ST_FIN) & mis_q;
`else
  assign LSU_MISALIGN = 1'b0;
`endif

endmodule
